// File: rtl/hazard_scheduler_pkg.sv
// +----------------------------------------------------------------------------+
// | hazard_scheduler_pkg                                                       |
// | Shared encodings, scoreboard entry type and hazard-match helper.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package hazard_scheduler_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [0:0] {
        HS_RUN      = 1'b0,
        HS_MEM_WAIT = 1'b1
    } hs_state_e;

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [4:0] dst;
        logic       ld;
    } sb_entry_t;

    // Register $0 is hard-wired to zero, so it can never be a true dependency.
    function automatic logic hz_match(input logic uses, input logic [4:0] src,
                                      input sb_entry_t e);
        return uses & e.v & e.wr & (e.dst == src) & (src != 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_scoreboard.sv
// +----------------------------------------------------------------------------+
// | pipe_scoreboard                                                            |
// | EX/MEM in-flight destination tracking, load-use detect, forward selects.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_scoreboard
    import hazard_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_reg_write,
    input  logic [4:0] id_dst,
    input  logic       id_is_load,
    input  logic       id_ex_en,
    input  logic       ex_mem_en,
    input  logic       id_ex_bubble,
    output logic       load_use,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    sb_entry_t  ex_q, ex_d, mem_q, mem_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
    logic [1:0] sel_a, sel_b;

    always_comb begin
        ex_rs_hit  = hz_match(id_uses_rs, id_rs, ex_q);
        ex_rt_hit  = hz_match(id_uses_rt, id_rt, ex_q);
        mem_rs_hit = hz_match(id_uses_rs, id_rs, mem_q);
        mem_rt_hit = hz_match(id_uses_rt, id_rt, mem_q);
        load_use   = (ex_rs_hit | ex_rt_hit) & ex_q.ld;
        // The younger (EX) producer wins over the older (MEM) one.
        sel_a = ex_rs_hit ? FWD_EXMEM : (mem_rs_hit ? FWD_MEMWB : FWD_RF);
        sel_b = ex_rt_hit ? FWD_EXMEM : (mem_rt_hit ? FWD_MEMWB : FWD_RF);

        ex_d    = ex_q;
        mem_d   = mem_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (id_ex_en) begin
            if (id_ex_bubble) begin
                ex_d    = '0;
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end else begin
                ex_d    = '{v: id_valid, wr: id_reg_write, dst: id_dst, ld: id_is_load};
                fwd_a_d = sel_a;
                fwd_b_d = sel_b;
            end
        end
        if (ex_mem_en) begin
            mem_d = ex_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scheduler.sv
// +----------------------------------------------------------------------------+
// | hazard_scheduler                                                           |
// | Pipeline advance/hold/flush control, memory-wait FSM and stall counters.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_reg_write,
    input  logic [4:0]             id_dst,
    input  logic                   id_is_load,
    input  logic                   ex_redirect,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   mem_error
);

    localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

    hs_state_e              state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic                   mem_error_q, mem_error_d;
    logic                   in_access, freeze, ready_seen, load_use;

    pipe_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_reg_write (id_reg_write),
        .id_dst       (id_dst),
        .id_is_load   (id_is_load),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .id_ex_bubble (id_ex_flush),
        .load_use     (load_use),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // The access completing this cycle releases the freeze in the same cycle.
    always_comb begin
        in_access  = mem_req | (state_q == HS_MEM_WAIT);
        freeze     = in_access & ~mem_ready;
        ready_seen = in_access & mem_ready;

        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HS_RUN:      if (mem_req && !mem_ready) state_d = HS_MEM_WAIT;
            HS_MEM_WAIT: if (mem_ready)             state_d = HS_RUN;
            default:                                state_d = HS_RUN;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (ready_seen) begin
            wait_cnt_d = '0;
        end else if (freeze && TIMEOUT_EN && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        mem_error_d = mem_error_q | (TIMEOUT_EN && freeze && (wait_cnt_d == WAIT_MAX));

        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HS_RUN;
            wait_cnt_q    <= '0;
            mem_error_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_error_q   <= mem_error_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign mem_error   = mem_error_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_hazard_scheduler                                                        |
// | Directed, queue-based self-checking bench for hazard_scheduler.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_scheduler;
    import hazard_scheduler_pkg::*;

    // Packed control word: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush}
    localparam logic [31:0] CTL_NORM = 32'h7C;
    localparam logic [31:0] CTL_LU   = 32'h1D;
    localparam logic [31:0] CTL_RDR  = 32'h7F;
    localparam logic [31:0] CTL_FRZ  = 32'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        ex_redirect, mem_req, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_error;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_count;

    logic [31:0] exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.MEM_TIMEOUT(4), .STALL_CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_reg_write (id_reg_write),
        .id_dst       (id_dst),
        .id_is_load   (id_is_load),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_count  (stall_count),
        .mem_error    (mem_error)
    );

    function automatic logic [31:0] ctl();
        return {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    endfunction

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed=%0h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic rw,
                          input logic [4:0] dst, input logic ld);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_reg_write = rw;
        id_dst       = dst;
        id_is_load   = ld;
    endtask

    initial begin
        rst = 1'b1;
        ex_redirect = 1'b0;
        mem_req = 1'b0;
        mem_ready = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        push(CTL_NORM); push(FWD_RF); push(FWD_RF); push(0); push(0);
        chk("rst_ctl", ctl());
        chk("rst_fwd_a", 32'(fwd_a));
        chk("rst_fwd_b", 32'(fwd_b));
        chk("rst_stall", stall_count);
        chk("rst_err", 32'(mem_error));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // addu $3 then addu reading $3: forward from EX/MEM, no stall
        set_id(1, 1, 2, 1, 1, 1, 3, 0);
        push(CTL_NORM); #1; chk("fwd_prod_ctl", ctl());
        tick();
        set_id(1, 3, 4, 1, 1, 1, 6, 0);
        push(CTL_NORM); push(FWD_EXMEM); push(FWD_RF);
        #1; chk("fwd_cons_ctl", ctl());
        tick();
        chk("fwd_exmem_a", 32'(fwd_a));
        chk("fwd_exmem_b", 32'(fwd_b));

        // $0 destination never forwards
        set_id(1, 7, 7, 1, 1, 1, 0, 0);
        tick();
        set_id(1, 0, 8, 1, 1, 0, 9, 0);
        push(FWD_RF); push(FWD_RF);
        tick();
        chk("zero_dst_a", 32'(fwd_a));
        chk("zero_dst_b", 32'(fwd_b));

        // lw $5 then addu reading rt=$5: one bubble, then MEM/WB forward
        set_id(1, 1, 0, 1, 0, 1, 5, 1);
        tick();
        set_id(1, 2, 5, 1, 1, 1, 10, 0);
        push(CTL_LU); #1; chk("lu_ctl", ctl());
        tick();
        push(CTL_NORM); push(1); push(FWD_RF);
        chk("lu_after_ctl", ctl());
        chk("lu_stall", stall_count);
        chk("lu_bubble_fwd_b", 32'(fwd_b));
        tick();
        push(FWD_MEMWB); push(FWD_RF); push(1);
        chk("lu_fwd_b", 32'(fwd_b));
        chk("lu_fwd_a", 32'(fwd_a));
        chk("lu_stall_hold", stall_count);

        // Redirect together with load-use: redirect wins, EX gets a bubble
        set_id(1, 0, 0, 0, 0, 1, 7, 1);
        tick();
        set_id(1, 7, 0, 1, 0, 1, 12, 0);
        ex_redirect = 1'b1;
        push(CTL_RDR); #1; chk("rdr_ctl", ctl());
        tick();
        ex_redirect = 1'b0;
        set_id(1, 12, 7, 1, 1, 1, 13, 0);
        push(CTL_NORM); push(FWD_RF); push(FWD_MEMWB); push(1);
        #1; chk("rdr_next_ctl", ctl());
        tick();
        chk("rdr_bubble_fwd_a", 32'(fwd_a));
        chk("rdr_fwd_b", 32'(fwd_b));
        chk("rdr_stall", stall_count);

        // Three-cycle memory wait: everything frozen, state held
        set_id(1, 13, 0, 1, 0, 0, 0, 0);
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(CTL_FRZ); push(FWD_MEMWB);
            #1; chk("wait_ctl", ctl());
            chk("wait_fwd_hold", 32'(fwd_b));
            tick();
        end
        mem_ready = 1'b1;
        push(CTL_NORM); push(4);
        #1; chk("wait_done_ctl", ctl());
        chk("wait_stall", stall_count);
        tick();
        mem_req = 1'b0;
        mem_ready = 1'b0;
        push(FWD_EXMEM); push(FWD_RF); push(0);
        chk("wait_sb_hold_a", 32'(fwd_a));
        chk("wait_after_b", 32'(fwd_b));
        chk("wait_no_err", 32'(mem_error));

        // Timeout after four frozen cycles; the flag is sticky
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            push((i == 3) ? 32'd1 : 32'd0);
            chk("timeout_err", 32'(mem_error));
        end
        mem_ready = 1'b1;
        push(CTL_NORM); #1; chk("timeout_release_ctl", ctl());
        tick();
        mem_req = 1'b0;
        mem_ready = 1'b0;
        push(1); push(8);
        chk("timeout_sticky", 32'(mem_error));
        chk("timeout_stall", stall_count);

        // Asynchronous reset in the middle of a wait
        set_id(1, 1, 0, 1, 0, 1, 20, 0);
        tick();
        set_id(1, 20, 0, 1, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        mem_req = 1'b1;
        push(FWD_EXMEM); chk("pre_rst_fwd_a", 32'(fwd_a));
        tick();
        #2;
        rst = 1'b1;
        mem_req = 1'b0;
        #1;
        push(CTL_NORM); push(FWD_RF); push(FWD_RF); push(0); push(0);
        chk("arst_ctl", ctl());
        chk("arst_fwd_a", 32'(fwd_a));
        chk("arst_fwd_b", 32'(fwd_b));
        chk("arst_stall", stall_count);
        chk("arst_err", 32'(mem_error));
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
